// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types, encodings and default timings for the phase scheduler
// Purpose: FSM state and approach encodings, default phase timings, and a
//          fixed-priority pick helper used for emergency arbitration.
// Ports:   none (package).
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED   = 2'd0,
    GREEN     = 2'd1,
    YELLOW    = 2'd2,
    EMG_GREEN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  localparam int DEF_T_ALLRED    = 2;
  localparam int DEF_T_YELLOW    = 4;
  localparam int DEF_T_GREEN_MIN = 8;
  localparam int DEF_T_GREEN_MAX = 24;

  // Lowest set index wins (N > E > S > W); returns 0 for an empty vector.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// rtl/phase_scheduler_if.sv - request/lamp bundle between controller and intersection
// Purpose: groups the demand inputs and lamp/grant outputs of phase_scheduler.
// Ports:   car_req, emg_req (to scheduler); emg_ack, green, yellow, red,
//          cur_dir (from scheduler). master = requester side, slave = scheduler.
interface phase_scheduler_if;
  logic [3:0] car_req;
  logic [3:0] emg_req;
  logic [3:0] emg_ack;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic [1:0] cur_dir;

  modport master (
    output car_req, emg_req,
    input  emg_ack, green, yellow, red, cur_dir
  );

  modport slave (
    input  car_req, emg_req,
    output emg_ack, green, yellow, red, cur_dir
  );
endinterface

// File: rtl/phase_scheduler_rr_pick4.sv
// rtl/phase_scheduler_rr_pick4.sv - round-robin pick among four approaches
// Purpose: finds the first set req bit searching upward from last+1 (mod 4).
// Ports:   req[3:0], last[1:0] in; valid, idx[1:0] out (combinational).
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk offsets from farthest (4 == last itself) to nearest (1) so the
  // nearest requester after last is the one left standing.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - four-approach traffic phase scheduler with emergency preemption
// Purpose: Moore FSM (ALL_RED, GREEN, YELLOW, EMG_GREEN) sequencing lamps for
//          four approaches, round-robin normal service, fixed-priority
//          emergency service with ack handshake.
// Ports:   Clk (rising edge), reset (sync, active low),
//          bus.slave: car_req/emg_req in; emg_ack/green/yellow/red/cur_dir out.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_GREEN_MAX = DEF_T_GREEN_MAX
) (
  input  logic                Clk,
  input  logic                reset,
  phase_scheduler_if.slave    bus
);

  localparam logic [1:0] ST_ALL_RED   = ALL_RED;
  localparam logic [1:0] ST_GREEN     = GREEN;
  localparam logic [1:0] ST_YELLOW    = YELLOW;
  localparam logic [1:0] ST_EMG_GREEN = EMG_GREEN;

  // Last count value of each timed interval; decisions fire at or past it.
  localparam logic [7:0] ALLRED_LAST    = 8'(T_ALLRED - 1);
  localparam logic [7:0] YELLOW_LAST    = 8'(T_YELLOW - 1);
  localparam logic [7:0] GREEN_MIN_LAST = 8'(T_GREEN_MIN - 1);
  localparam logic [7:0] GREEN_MAX_LAST = 8'(T_GREEN_MAX - 1);

  logic [1:0] state, state_nx;
  logic [7:0] count;
  logic [1:0] cur_dir, dir_nx;
  logic [1:0] last_served;
  logic [3:0] dir_mask;
  logic       other_car, other_emg;
  logic       rr_valid;
  logic [1:0] rr_idx;
  logic       entering_green;

  rr_pick4 u_rr (
    .req   (bus.car_req),
    .last  (last_served),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  assign dir_mask  = 4'b0001 << cur_dir;
  assign other_car = |(bus.car_req & ~dir_mask);
  assign other_emg = |(bus.emg_req & ~dir_mask);

  always_comb begin
    state_nx = state;
    dir_nx   = cur_dir;
    case (state)
      ST_ALL_RED: begin
        if (count >= ALLRED_LAST) begin
          if (|bus.emg_req) begin
            state_nx = ST_EMG_GREEN;
            dir_nx   = lowest_set(bus.emg_req);
          end else if (rr_valid) begin
            state_nx = ST_GREEN;
            dir_nx   = rr_idx;
          end
        end
      end
      ST_GREEN: begin
        // Own emergency converts the green in place; a foreign one cuts it
        // short regardless of minimum green.
        if (bus.emg_req[cur_dir]) begin
          state_nx = ST_EMG_GREEN;
        end else if (other_emg) begin
          state_nx = ST_YELLOW;
        end else if (other_car &&
                     (count >= GREEN_MIN_LAST || count >= GREEN_MAX_LAST)) begin
          state_nx = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (count >= YELLOW_LAST) state_nx = ST_ALL_RED;
      end
      ST_EMG_GREEN: begin
        if (!bus.emg_req[cur_dir]) state_nx = ST_YELLOW;
      end
      default: state_nx = ST_ALL_RED;
    endcase
  end

  assign entering_green = (state_nx != state) &&
                          (state_nx == ST_GREEN || state_nx == ST_EMG_GREEN);

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state       <= ST_ALL_RED;
      count       <= 8'd0;
      cur_dir     <= 2'd0;
      last_served <= 2'd3;
    end else begin
      state   <= state_nx;
      cur_dir <= dir_nx;
      if (state_nx != state) begin
        count <= 8'd0;
      end else if (count != 8'hFF) begin
        count <= count + 8'd1;
      end
      if (entering_green) last_served <= dir_nx;
    end
  end

  // Lamps and grant decode straight from registered state and direction.
  always_comb begin
    bus.green   = 4'b0000;
    bus.yellow  = 4'b0000;
    bus.emg_ack = 4'b0000;
    if (state == ST_GREEN || state == ST_EMG_GREEN) bus.green = dir_mask;
    if (state == ST_YELLOW) bus.yellow = dir_mask;
    if (state == ST_EMG_GREEN) bus.emg_ack = dir_mask;
    bus.red = ~(bus.green | bus.yellow);
  end

  assign bus.cur_dir = cur_dir;

endmodule

// File: tb/tb_phase_scheduler.sv
// tb/tb_phase_scheduler.sv - self-checking bench for phase_scheduler
// Purpose: directed scenarios with literal expectations plus a per-cycle
//          comparison against a phase/elapsed-time model of the intersection.
// Ports:   none (top-level bench).
module tb_phase_scheduler;

  localparam int TA = 2;
  localparam int TY = 4;
  localparam int TGMIN = 8;
  localparam int TGMAX = 24;

  localparam int P_AR  = 0;
  localparam int P_GRN = 1;
  localparam int P_YEL = 2;
  localparam int P_EMG = 3;

  logic clk;
  logic reset_v;
  int   checks;
  int   failures;

  phase_scheduler_if psif ();

  phase_scheduler #(
    .T_ALLRED    (TA),
    .T_YELLOW    (TY),
    .T_GREEN_MIN (TGMIN),
    .T_GREEN_MAX (TGMAX)
  ) dut (
    .Clk   (clk),
    .reset (reset_v),
    .bus   (psif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: which phase is lit, for how many cycles, for whom, and who was
  // last given right of way.
  int  m_ph, m_el, m_dir, m_last;
  bit  m_valid = 0;

  always @(posedge clk) begin
    logic [3:0] car, emg;
    int nph, ndir;
    car = psif.car_req;
    emg = psif.emg_req;
    if (!reset_v) begin
      m_ph = P_AR; m_el = 0; m_dir = 0; m_last = 3; m_valid = 1;
    end else if (m_valid) begin
      nph = m_ph;
      ndir = m_dir;
      if (m_ph == P_AR) begin
        if (m_el + 1 >= TA) begin
          if (emg != 0) begin
            for (int i = 3; i >= 0; i--) if (emg[i]) ndir = i;
            nph = P_EMG;
          end else if (car != 0) begin
            for (int k = 4; k >= 1; k--) if (car[(m_last + k) % 4]) ndir = (m_last + k) % 4;
            nph = P_GRN;
          end
        end
      end else if (m_ph == P_GRN) begin
        if (emg[m_dir]) nph = P_EMG;
        else if ((emg & ~(4'b1 << m_dir)) != 0) nph = P_YEL;
        else if ((car & ~(4'b1 << m_dir)) != 0 && m_el + 1 >= TGMIN) nph = P_YEL;
      end else if (m_ph == P_YEL) begin
        if (m_el + 1 >= TY) nph = P_AR;
      end else begin
        if (!emg[m_dir]) nph = P_YEL;
      end
      if (nph != m_ph) begin
        m_el = 0;
        if (nph == P_GRN || nph == P_EMG) m_last = ndir;
      end else begin
        m_el++;
      end
      m_ph = nph;
      m_dir = ndir;
    end
  end

  always @(negedge clk) begin
    logic [3:0] eg, ey, ea;
    if (m_valid) begin
      eg = (m_ph == P_GRN || m_ph == P_EMG) ? (4'b1 << m_dir) : 4'b0;
      ey = (m_ph == P_YEL) ? (4'b1 << m_dir) : 4'b0;
      ea = (m_ph == P_EMG) ? (4'b1 << m_dir) : 4'b0;
      chk("model_green", psif.green, eg);
      chk("model_yellow", psif.yellow, ey);
      chk("model_red", psif.red, ~(eg | ey));
      chk("model_ack", psif.emg_ack, ea);
      chk("model_cur_dir", {2'b00, psif.cur_dir}, 4'(m_dir));
      chk("lamp_invariant",
          {3'b000, ($countones(psif.green) > 1) || ((psif.green & psif.yellow) != 0)}, 4'b0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic hold(input int n, input logic [3:0] g, input logic [3:0] y, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_green"}, psif.green, g);
      chk({tag, "_yellow"}, psif.yellow, y);
      step();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_v = 1'b0;
    psif.car_req = 4'b0;
    psif.emg_req = 4'b0;

    step();
    chk("rst_red", psif.red, 4'b1111);
    chk("rst_green", psif.green, 4'b0000);
    chk("rst_yellow", psif.yellow, 4'b0000);
    chk("rst_ack", psif.emg_ack, 4'b0000);
    chk("rst_cur_dir", {2'b00, psif.cur_dir}, 4'd0);

    reset_v = 1'b1;
    psif.car_req = 4'b0100;
    step(); step();
    chk("s_first_green", psif.green, 4'b0100);
    chk("s_first_red", psif.red, 4'b1011);
    chk("s_first_dir", {2'b00, psif.cur_dir}, 4'd2);

    psif.car_req = 4'b0101;
    hold(8, 4'b0100, 4'b0000, "s_green");
    hold(4, 4'b0000, 4'b0100, "s_yellow");
    hold(2, 4'b0000, 4'b0000, "s_allred");
    chk("n_after_s", psif.green, 4'b0001);

    reset_v = 1'b0;
    psif.car_req = 4'b1111;
    step();
    chk("rst2_red", psif.red, 4'b1111);
    reset_v = 1'b1;
    step(); step();
    for (int d = 0; d < 4; d++) begin
      hold(8, 4'b0001 << d, 4'b0000, "rr_green");
      hold(4, 4'b0000, 4'b0001 << d, "rr_yellow");
      hold(2, 4'b0000, 4'b0000, "rr_allred");
    end
    chk("rr_wrap_n", psif.green, 4'b0001);

    psif.car_req = 4'b0000;
    hold(3, 4'b0001, 4'b0000, "pre_green");
    psif.emg_req = 4'b0010;
    step();
    chk("preempt_yellow", psif.yellow, 4'b0001);
    chk("preempt_no_green", psif.green, 4'b0000);
    hold(4, 4'b0000, 4'b0001, "preempt_yellow");
    hold(2, 4'b0000, 4'b0000, "preempt_allred");
    chk("emg_e_green", psif.green, 4'b0010);
    chk("emg_e_ack", psif.emg_ack, 4'b0010);
    chk("emg_e_dir", {2'b00, psif.cur_dir}, 4'd1);
    hold(3, 4'b0010, 4'b0000, "emg_e_hold");
    chk("emg_e_ack_held", psif.emg_ack, 4'b0010);
    psif.emg_req = 4'b0000;
    step();
    chk("emg_e_release_ack", psif.emg_ack, 4'b0000);
    chk("emg_e_release_yel", psif.yellow, 4'b0010);

    psif.car_req = 4'b0001;
    hold(4, 4'b0000, 4'b0010, "e_yellow");
    hold(2, 4'b0000, 4'b0000, "e_allred");
    chk("n_green_again", psif.green, 4'b0001);
    psif.emg_req = 4'b0001;
    step();
    chk("own_emg_ack", psif.emg_ack, 4'b0001);
    chk("own_emg_green", psif.green, 4'b0001);
    chk("own_emg_no_yel", psif.yellow, 4'b0000);
    step();
    chk("own_emg_ack2", psif.emg_ack, 4'b0001);
    psif.emg_req = 4'b1010;
    psif.car_req = 4'b0000;
    step();
    chk("own_emg_exit_yel", psif.yellow, 4'b0001);
    chk("own_emg_exit_ack", psif.emg_ack, 4'b0000);
    hold(4, 4'b0000, 4'b0001, "n_yellow");
    hold(2, 4'b0000, 4'b0000, "n_allred");
    chk("prio_e_ack", psif.emg_ack, 4'b0010);
    chk("prio_e_dir", {2'b00, psif.cur_dir}, 4'd1);
    hold(2, 4'b0010, 4'b0000, "prio_e_hold");
    psif.emg_req = 4'b1000;
    step();
    hold(4, 4'b0000, 4'b0010, "prio_e_yellow");
    hold(2, 4'b0000, 4'b0000, "prio_e_allred");
    chk("prio_w_ack", psif.emg_ack, 4'b1000);
    chk("prio_w_green", psif.green, 4'b1000);

    reset_v = 1'b0;
    step();
    chk("emg_abort_red", psif.red, 4'b1111);
    chk("emg_abort_ack", psif.emg_ack, 4'b0000);
    chk("emg_abort_yel", psif.yellow, 4'b0000);

    reset_v = 1'b1;
    psif.emg_req = 4'b0000;
    psif.car_req = 4'b0001;
    step(); step();
    hold(30, 4'b0001, 4'b0000, "solo_hold");
    psif.car_req = 4'b0011;
    step();
    chk("late_demand_yel", psif.yellow, 4'b0001);
    step(); step();

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
